// File: rtl/branch_pkg.sv
// Shared types for the branch resolver: default PC width, pipeline metadata record
// and the mispredict reason code carried alongside each resolve.
package branch_pkg;

    localparam int ADDR_W_DEFAULT = 32;

    typedef struct packed {
        logic                      v;
        logic                      br;
        logic                      ptk;
        logic [ADDR_W_DEFAULT-1:0] paddr;
        logic [ADDR_W_DEFAULT-1:0] pc;
    } branch_meta_t;

    typedef enum logic [2:0] {
        NONE,
        NOT_TAKEN,
        TAKEN_MISS,
        TARGET_MISS,
        ALIAS
    } redirect_reason_e;

endpackage

// File: rtl/branch_meta_stage.sv
// One prediction-metadata pipeline register; 1-cycle latency.
// hold keeps the contents, kill clears the record and wins over hold.
module branch_meta_stage
    import branch_pkg::*;
#(
    parameter type meta_t = branch_meta_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  hold,
    input  logic  kill,
    input  meta_t d,
    output meta_t q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (kill) begin
            q <= '0;
        end else if (!hold) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_resolver.sv
// Carries fetch predictions F->D->X and resolves them against the EXEC outcome;
// outputs registered, pulse 2 edges after DECODE; stall freezes the pipe and gates resolves.
// Optional saturating hit/miss counters under BRANCH_RESOLVER_STATS_EN.
module branch_resolver
    import branch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [ADDR_W-1:0] f_pc,
    input  logic              f_predict_valid,
    input  logic [ADDR_W-1:0] f_predict_addr,
    input  logic              d_is_branch,
    input  logic              x_taken,
    input  logic [ADDR_W-1:0] x_target,
    output logic              x_predict_res,
    output logic [ADDR_W-1:0] x_train_pc,
    output logic [ADDR_W-1:0] x_train_target,
    output logic              x_redirect,
    output logic [ADDR_W-1:0] x_redirect_pc
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    typedef struct packed {
        logic              v;
        logic              br;
        logic              ptk;
        logic [ADDR_W-1:0] paddr;
        logic [ADDR_W-1:0] pc;
    } meta_t;

    meta_t            d_meta, x_meta, d_next, x_next;
    redirect_reason_e reason;
    logic             train, mispredict;
    logic [ADDR_W-1:0] fix_pc;

    always_comb begin
        d_next       = '{v: 1'b1, br: 1'b0, ptk: f_predict_valid, paddr: f_predict_addr, pc: f_pc};
        x_next       = d_meta;
        x_next.br    = d_is_branch;
    end

    always_comb begin
        reason = NONE;
        train  = 1'b0;
        fix_pc = x_meta.pc + ADDR_W'(1);
        if (x_meta.v && !stall) begin
            if (x_meta.br && x_taken) begin
                train  = 1'b1;
                fix_pc = x_target;
                if (!x_meta.ptk) begin
                    reason = TAKEN_MISS;
                end else if (x_meta.paddr != x_target) begin
                    reason = TARGET_MISS;
                end
            end else if (x_meta.ptk) begin
                reason = x_meta.br ? NOT_TAKEN : ALIAS;
            end
        end
    end

    assign mispredict = (reason != NONE);

    // D is also killed the edge after a redirect: that fetch came from the stale stream.
    branch_meta_stage #(.meta_t(meta_t)) u_d_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (stall),
        .kill  (mispredict || x_redirect),
        .d     (d_next),
        .q     (d_meta)
    );

    branch_meta_stage #(.meta_t(meta_t)) u_x_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (stall),
        .kill  (mispredict),
        .d     (x_next),
        .q     (x_meta)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_predict_res  <= 1'b0;
            x_train_pc     <= '0;
            x_train_target <= '0;
            x_redirect     <= 1'b0;
            x_redirect_pc  <= '0;
        end else begin
            x_predict_res  <= train;
            x_train_pc     <= train ? x_meta.pc : '0;
            x_train_target <= train ? x_target : '0;
            x_redirect     <= mispredict;
            x_redirect_pc  <= mispredict ? fix_pc : '0;
        end
    end

`ifdef BRANCH_RESOLVER_STATS_EN
    logic hit;
    assign hit = x_meta.v && !stall && x_meta.br && !mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else begin
            if (hit && stat_hits != 32'hFFFF_FFFF) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (mispredict && stat_misses != 32'hFFFF_FFFF) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end
`else
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed scenarios plus random traffic against a queue-based model of in-flight instructions.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic [31:0] f_pc = '0;
    logic        f_predict_valid = 1'b0;
    logic [31:0] f_predict_addr = '0;
    logic        d_is_branch = 1'b0;
    logic        x_taken = 1'b0;
    logic [31:0] x_target = '0;
    logic        x_predict_res;
    logic [31:0] x_train_pc;
    logic [31:0] x_train_target;
    logic        x_redirect;
    logic [31:0] x_redirect_pc;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    branch_resolver #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .f_pc            (f_pc),
        .f_predict_valid (f_predict_valid),
        .f_predict_addr  (f_predict_addr),
        .d_is_branch     (d_is_branch),
        .x_taken         (x_taken),
        .x_target        (x_target),
        .x_predict_res   (x_predict_res),
        .x_train_pc      (x_train_pc),
        .x_train_target  (x_train_target),
        .x_redirect      (x_redirect),
        .x_redirect_pc   (x_redirect_pc)
`ifdef BRANCH_RESOLVER_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          valid;
        bit          isbr;
        bit          ptk;
        bit          taken;
        logic [31:0] pc;
        logic [31:0] paddr;
        logic [31:0] target;
    } rec_t;

    // pipe[0] is the instruction in EXEC, pipe[1] the one in DECODE.
    rec_t        pipe[$];
    bit          drop;
    bit          e_res, e_red;
    logic [31:0] e_tpc, e_ttg, e_rpc;
    int          m_hits, m_misses;
    int          checks = 0, passes = 0, fails = 0;
    int unsigned filler_pc = 32'h100;

    function automatic rec_t bubble();
        rec_t r;
        r = '{default: '0};
        return r;
    endfunction

    function automatic rec_t mk(logic [31:0] pc, bit isbr, bit ptk, logic [31:0] paddr,
                                bit taken, logic [31:0] target);
        rec_t r;
        r = '{valid: 1'b1, isbr: isbr, ptk: ptk, taken: taken, pc: pc, paddr: paddr, target: target};
        return r;
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(bubble());
        pipe.push_back(bubble());
        drop = 1'b0;
        {e_res, e_red} = '0;
        {e_tpc, e_ttg, e_rpc} = '0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic model_edge(bit st, rec_t f);
        rec_t r;
        {e_res, e_red} = '0;
        {e_tpc, e_ttg, e_rpc} = '0;
        if (st) begin
            drop = 1'b0;
            return;
        end
        r = pipe[0];
        if (r.valid) begin
            if (r.isbr && r.taken) begin
                e_res = 1'b1;
                e_tpc = r.pc;
                e_ttg = r.target;
                if (!r.ptk || r.paddr != r.target) begin
                    e_red = 1'b1;
                    e_rpc = r.target;
                end
            end else if (r.ptk) begin
                e_red = 1'b1;
                e_rpc = r.pc + 32'd1;
            end
            if (e_red) m_misses++;
            else if (r.isbr) m_hits++;
        end
        if (e_red) begin
            pipe[0] = bubble();
            pipe[1] = bubble();
            drop = 1'b1;
        end else begin
            void'(pipe.pop_front());
            pipe.push_back(drop ? bubble() : f);
            drop = 1'b0;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("x_predict_res", {31'd0, x_predict_res}, {31'd0, e_res});
        chk("x_train_pc", x_train_pc, e_tpc);
        chk("x_train_target", x_train_target, e_ttg);
        chk("x_redirect", {31'd0, x_redirect}, {31'd0, e_red});
        chk("x_redirect_pc", x_redirect_pc, e_rpc);
`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_hits", stat_hits, m_hits);
        chk("stat_misses", stat_misses, m_misses);
`endif
    endtask

    task automatic cycle(bit st, rec_t f);
        stall           = st;
        f_pc            = f.pc;
        f_predict_valid = f.ptk;
        f_predict_addr  = f.paddr;
        d_is_branch     = pipe[1].valid ? pipe[1].isbr : 1'($urandom);
        x_taken         = pipe[0].valid ? pipe[0].taken : 1'($urandom);
        x_target        = pipe[0].valid ? pipe[0].target : $urandom;
        @(posedge clk);
        model_edge(st, f);
        #1;
        check_outputs();
    endtask

    task automatic fill(int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, mk(filler_pc, 1'b0, 1'b0, 32'h0, 1'($urandom), $urandom));
            filler_pc++;
        end
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
    endtask

    initial begin
        rec_t r;
        model_reset();
        @(posedge clk);
        #1;
        reset_pulse();

        // Predicted taken, taken, correct target
        cycle(1'b0, mk(32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10));
        fill(3);

        // Cold miss; the three aliasing fetches behind it must be squashed
        cycle(1'b0, mk(32'h4, 1'b1, 1'b0, 32'h0, 1'b1, 32'h20));
        for (int i = 0; i < 3; i++) cycle(1'b0, mk(32'h200 + i, 1'b0, 1'b1, 32'h300, 1'b0, 32'h0));
        fill(3);

        // Predicted taken, not taken
        cycle(1'b0, mk(32'h8, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0));
        fill(3);

        // Alias on a non-branch at the top of the address space
        cycle(1'b0, mk(32'hFFFF_FFFF, 1'b0, 1'b1, 32'h5, 1'b1, 32'h77));
        fill(3);

`ifdef BRANCH_RESOLVER_STATS_EN
        chk("stat_hits_after_s4", stat_hits, 32'd1);
        chk("stat_misses_after_s4", stat_misses, 32'd3);
`endif

        // Stall three cycles with a branch held in EXEC
        cycle(1'b0, mk(32'h50, 1'b1, 1'b1, 32'h60, 1'b1, 32'h60));
        fill(1);
        for (int i = 0; i < 3; i++) cycle(1'b1, mk(32'h400 + i, 1'b0, 1'b1, 32'h1, 1'b0, 32'h0));
        fill(3);

        // Reset while a train pulse is visible and an alias sits in EXEC
        cycle(1'b0, mk(32'h70, 1'b1, 1'b1, 32'h80, 1'b1, 32'h80));
        cycle(1'b0, mk(32'h71, 1'b0, 1'b1, 32'h90, 1'b0, 32'h0));
        fill(1);
        chk("pulse_before_reset", {31'd0, x_predict_res}, 32'd1);
        reset_pulse();
        fill(4);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r.valid  = 1'b1;
            r.pc     = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
            r.isbr   = 1'($urandom);
            r.ptk    = 1'($urandom);
            r.taken  = 1'($urandom);
            r.target = $urandom;
            r.paddr  = ($urandom_range(0, 2) != 0) ? r.target : $urandom;
            cycle($urandom_range(0, 7) == 0, r);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
